// File: rtl/writeback_register_file.sv
// Architectural integer register file fed by the execute/writeback pipeline register.
// Optional macro WRITEBACK_REGFILE_BYPASS_EN selects write-first bypass (default: read-first).
`timescale 1ns/1ps
module writeback_register_file #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 5,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   reg_write_en_in,
   input  logic [DATA_WIDTH-1:0]  write_data_in,
   input  logic [ADDR_WIDTH-1:0]  write_addr_in,
   input  logic [ADDR_WIDTH-1:0]  rs1_addr,
   input  logic [ADDR_WIDTH-1:0]  rs2_addr,
   output logic [DATA_WIDTH-1:0]  rs1_data,
   output logic [DATA_WIDTH-1:0]  rs2_data,
   output logic [COUNT_WIDTH-1:0] commit_count,
   output logic [ADDR_WIDTH-1:0]  last_write_addr,
   output logic                   last_write_valid
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]  regs_q [DEPTH];
   logic [COUNT_WIDTH-1:0] commit_q, commit_d;
   logic [ADDR_WIDTH-1:0]  last_addr_q, last_addr_d;
   logic                   last_valid_q, last_valid_d;
   logic                   write_eff;

   // Writes to entry 0 are architecturally invisible and must not touch debug state.
   assign write_eff = reg_write_en_in && (write_addr_in != '0) && !rst;

   always_comb begin
      commit_d     = commit_q;
      last_addr_d  = last_addr_q;
      last_valid_d = last_valid_q;
      if (write_eff) begin
         commit_d     = commit_q + COUNT_WIDTH'(1);
         last_addr_d  = write_addr_in;
         last_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         commit_q     <= '0;
         last_addr_q  <= '0;
         last_valid_q <= 1'b0;
      end else begin
         if (write_eff) begin
            regs_q[write_addr_in] <= write_data_in;
         end
         commit_q     <= commit_d;
         last_addr_q  <= last_addr_d;
         last_valid_q <= last_valid_d;
      end
   end

   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_addr != '0) begin
         rs1_data = regs_q[rs1_addr];
      end
      if (rs2_addr != '0) begin
         rs2_data = regs_q[rs2_addr];
      end
`ifdef WRITEBACK_REGFILE_BYPASS_EN
      // write_eff already excludes index 0, so entry 0 can never be bypassed.
      if (write_eff && (rs1_addr == write_addr_in)) begin
         rs1_data = write_data_in;
      end
      if (write_eff && (rs2_addr == write_addr_in)) begin
         rs2_data = write_data_in;
      end
`endif
   end

   assign commit_count     = commit_q;
   assign last_write_addr  = last_addr_q;
   assign last_write_valid = last_valid_q;

endmodule
